branch_ctrl: RTL
================

# branch_ctrl

Pipeline controller for the ID-stage branch unit of the 16-bit core. Detects data hazards on the branch operands (RD1 source register and implicit R0), stalls IF/ID and bubbles ID/EX until operands are forwardable, then sequences the taken-branch redirect and IF/ID flush using the branch unit's `taken` flag and target. It also keeps saturating performance counters for branch stall cycles and taken branches.

## Interface
Parameters:
- DW, 16, data/PC width
- RW, 4, register address width
- CW, 16, performance counter width

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_opcode  in  4  ID opcode; branches are 4'b0100 (BLT), 4'b0101 (BGT), 4'b0110 (BEQ)
- id_rs  in  RW  register address feeding RD1
- ex_wr_en, ex_is_load  in  1 each  EX instruction writes a register / is a load
- ex_rd  in  RW  EX destination
- mem_wr_en, mem_is_load  in  1 each  MEM-stage equivalents
- mem_rd  in  RW  MEM destination
- br_taken  in  1  branch unit comparison result (valid when operands are ready)
- br_target  in  DW  branch unit target (pc + offset)
- cnt_clr  in  1  synchronous clear of both counters
- stall_if, stall_id  out  1  hold PC and IF/ID
- bubble_ex  out  1  insert NOP into ID/EX
- flush_ifid  out  1  clear IF/ID
- pc_sel  out  1  select pc_target as next PC
- pc_target  out  DW  registered redirect target
- stall_cnt, taken_cnt  out  CW  saturating counters

## Operation
- is_br = id_valid & opcode in {0100, 0101, 0110}. Sources are id_rs and register 0.
- need (hazard depth, 0..2): if ex_wr_en and ex_rd matches a source -> 2 when ex_is_load, else 1. Otherwise, if mem_wr_en & mem_is_load and mem_rd matches a source -> 1. Otherwise 0. When EX and MEM both match, EX decides.
- States: IDLE, STALL, REDIRECT.
- IDLE/STALL with is_br & need>0:
  - stall_if = stall_id = bubble_ex = 1 (combinational, same cycle)
  - next state STALL
  - stall_cnt += 1
- IDLE/STALL with is_br & need==0: br_taken is sampled.
  - If taken: pc_target <= br_target, taken_cnt += 1, next state REDIRECT.
  - If not taken: next state IDLE.
  - No stall in either case.
- IDLE/STALL with !is_br: next state IDLE and all outputs 0. A STALL whose instruction disappears returns to IDLE.
- REDIRECT lasts exactly one cycle:
  - pc_sel = 1 and flush_ifid = 1; stall outputs 0.
  - The ID instruction is wrong-path and is ignored, even if it is a branch.
  - Next state IDLE.
- Hazard depth is re-evaluated every cycle; there is no internal countdown.
- Counters:
  - Saturate at all-ones.
  - cnt_clr has priority over increment in the same cycle.

## Timing
- Reset (asynchronous, immediate): state IDLE; pc_target, stall_cnt and taken_cnt = 0. All Moore outputs 0; Mealy outputs are 0 while rst_n is low.
- Stall outputs are Mealy (same cycle as the hazard). pc_sel and flush_ifid are Moore (REDIRECT only).
- Taken-branch latency: resolve in cycle T, redirect in T+1. An untaken branch costs 0 cycles.
- Stall length:
  - EX-load dependency: 2 cycles.
  - EX-ALU dependency: 1 cycle.
  - MEM-load dependency: 1 cycle.
- Reset during REDIRECT or STALL aborts the sequence. pc_sel drops immediately and no redirect occurs after reset release.

## Structure
- Package branch_ctrl_pkg:
  - opcode constants OP_BLT/OP_BGT/OP_BEQ
  - state enum {IDLE, STALL, REDIRECT}
  - function is_branch(opcode)
- Sub-module branch_hazard_detect: combinational need computation (sources vs. EX/MEM destinations).
- branch_ctrl: holds the FSM, the target register and the counters.

## Test plan
- Branch with no hazard: BEQ, rs=3, br_taken=1, br_target=0x0004 -> T+1: pc_sel=1, flush_ifid=1, pc_target=0x0004; taken_cnt=1; stall_cnt=0.
- EX load with ex_rd=3 (matches rs=3): BLT in ID -> stall_if/stall_id/bubble_ex high for 2 cycles (load moves to MEM) -> resolves the third cycle; stall_cnt=2.
- EX ALU write to R0 with rs=5: BGT -> 1-cycle stall. Then br_taken=0 -> no redirect; state IDLE.
- EX ALU and MEM load both target rs -> EX rule governs: exactly 1 stall cycle, then resolve.
- Branch in ID during REDIRECT -> ignored: no second redirect, taken_cnt unchanged.
- rst_n pulsed low during REDIRECT -> pc_sel=0 immediately, counters 0. Also: saturation at 0xFFFF holds; cnt_clr together with an increment yields 0.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: opcodes, FSM states and branch decode for the ID-stage branch controller
package branch_ctrl_pkg;
  localparam logic [3:0] OP_BLT = 4'b0100;
  localparam logic [3:0] OP_BGT = 4'b0101;
  localparam logic [3:0] OP_BEQ = 4'b0110;
  typedef enum logic [1:0] {IDLE, STALL, REDIRECT} state_t;
  function automatic logic is_branch(input logic [3:0] opcode);
    return (opcode == OP_BLT) | (opcode == OP_BGT) | (opcode == OP_BEQ);
  endfunction
endpackage

// File: rtl/branch_hazard_detect.sv
// branch_hazard_detect: stall depth needed before the branch operands (rs and R0) are forwardable
module branch_hazard_detect #(
  parameter int RW = 4
) (
  input  logic [RW-1:0] id_rs,
  input  logic          ex_wr_en,
  input  logic          ex_is_load,
  input  logic [RW-1:0] ex_rd,
  input  logic          mem_wr_en,
  input  logic          mem_is_load,
  input  logic [RW-1:0] mem_rd,
  output logic [1:0]    need
);
  logic ex_hit, mem_hit;
  // R0 is an implicit operand of every branch, so a pending write to it always counts
  assign ex_hit  = ex_wr_en & ((ex_rd == id_rs) | (ex_rd == '0));
  assign mem_hit = mem_wr_en & mem_is_load & ((mem_rd == id_rs) | (mem_rd == '0));
  assign need    = ex_hit ? (ex_is_load ? 2'd2 : 2'd1) : {1'b0, mem_hit};
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: branch hazard stall, taken-branch redirect/flush and saturating perf counters
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [3:0]    id_opcode,
  input  logic [RW-1:0] id_rs,
  input  logic          ex_wr_en,
  input  logic          ex_is_load,
  input  logic [RW-1:0] ex_rd,
  input  logic          mem_wr_en,
  input  logic          mem_is_load,
  input  logic [RW-1:0] mem_rd,
  input  logic          br_taken,
  input  logic [DW-1:0] br_target,
  input  logic          cnt_clr,
  output logic          stall_if,
  output logic          stall_id,
  output logic          bubble_ex,
  output logic          flush_ifid,
  output logic          pc_sel,
  output logic [DW-1:0] pc_target,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] taken_cnt
);
  state_t     state;
  logic [1:0] need;
  logic       act, stall, res_taken;
  branch_hazard_detect #(.RW(RW)) u_hazard (
    .id_rs       (id_rs),
    .ex_wr_en    (ex_wr_en),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .mem_wr_en   (mem_wr_en),
    .mem_is_load (mem_is_load),
    .mem_rd      (mem_rd),
    .need        (need)
  );
  // the ID instruction behind a redirect is wrong-path and never acted on
  assign act       = id_valid & is_branch(id_opcode) & (state != REDIRECT);
  assign stall     = rst_n & act & (need != 2'd0);
  assign res_taken = act & (need == 2'd0) & br_taken;
  assign stall_if  = stall;
  assign stall_id  = stall;
  assign bubble_ex = stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc_sel     <= 1'b0;
      flush_ifid <= 1'b0;
      pc_target  <= '0;
      stall_cnt  <= '0;
      taken_cnt  <= '0;
    end else begin
      state      <= stall ? STALL : res_taken ? REDIRECT : IDLE;
      pc_sel     <= res_taken;
      flush_ifid <= res_taken;
      if (res_taken) pc_target <= br_target;
      stall_cnt  <= cnt_clr ? '0 : stall_cnt + CW'(stall & ~&stall_cnt);
      taken_cnt  <= cnt_clr ? '0 : taken_cnt + CW'(res_taken & ~&taken_cnt);
    end
  end
endmodule
